test_ram_reader: RTL and testbench

Streaming read engine for the 256x32 simple dual-port test RAM. It owns the RAM read port (address out, data in, one-cycle read latency, no output register). On a start command it reads `length` consecutive words beginning at `start_addr` and presents them as a valid/ready stream with a last flag. It sits between the RAM read port and the Cortex-M1-side consumer; the write side of the RAM is driven elsewhere.

---
 rtl/test_ram_reader.sv | 152 +++++++++++++++
 tb/tb_test_ram_reader.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/test_ram_reader.sv
// Streaming read engine for the 256x32 test RAM: reads a run of words and presents them as a valid/ready stream.
// Optional abort input is compiled in when TEST_RAM_READER_ABORT_EN is defined.
module test_ram_reader #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  rd_clk,
    input  logic                  rd_rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    input  logic [ADDR_WIDTH:0]   length,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] ram_rd_addr,
    input  logic [DATA_WIDTH-1:0] ram_rd_data,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_last
`ifdef TEST_RAM_READER_ABORT_EN
    ,
    input  logic                  abort
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH:0]   LEN_ONE  = (ADDR_WIDTH + 1)'(1);
    localparam logic [ADDR_WIDTH:0]   LEN_ZERO = (ADDR_WIDTH + 1)'(0);

    state_e                  state_q;
    logic [ADDR_WIDTH-1:0]   ptr_q;
    logic [ADDR_WIDTH:0]     remaining_q;
    logic                    pend_q;
    logic                    pend_last_q;
    logic                    done_q;
    logic [DATA_WIDTH-1:0]   fifo_data_q [4];
    logic                    fifo_last_q [4];
    logic [1:0]              wr_ptr_q;
    logic [1:0]              rd_ptr_q;
    logic [2:0]              fifo_count_q;
    logic [2:0]              fifo_count_d;

    logic abort_s;
    logic issue_s;
    logic final_issue_s;
    logic push_s;
    logic pop_s;

`ifdef TEST_RAM_READER_ABORT_EN
    assign abort_s = abort & (state_q != ST_IDLE);
`else
    assign abort_s = 1'b0;
`endif

    // Credit check counts the read still in flight; pops this cycle are not credited.
    always_comb begin
        issue_s       = (state_q == ST_RUN) && (remaining_q != LEN_ZERO) &&
                        (({1'b0, fifo_count_q} + {3'b000, pend_q}) < 4'd4);
        final_issue_s = issue_s && (remaining_q == LEN_ONE);
        push_s        = pend_q;
        pop_s         = (fifo_count_q != 3'd0) && m_ready;
        case ({push_s, pop_s})
            2'b10:   fifo_count_d = fifo_count_q + 3'd1;
            2'b01:   fifo_count_d = fifo_count_q - 3'd1;
            default: fifo_count_d = fifo_count_q;
        endcase
    end

    assign busy        = (state_q != ST_IDLE);
    assign done        = done_q;
    assign ram_rd_addr = ptr_q;
    assign m_valid     = (fifo_count_q != 3'd0);
    assign m_data      = fifo_data_q[rd_ptr_q];
    assign m_last      = fifo_last_q[rd_ptr_q] & m_valid;

    // Control FSM, read pointer and output FIFO.
    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            state_q      <= ST_IDLE;
            ptr_q        <= '0;
            remaining_q  <= '0;
            pend_q       <= 1'b0;
            pend_last_q  <= 1'b0;
            done_q       <= 1'b0;
            wr_ptr_q     <= 2'd0;
            rd_ptr_q     <= 2'd0;
            fifo_count_q <= 3'd0;
            for (int i = 0; i < 4; i++) begin
                fifo_data_q[i] <= '0;
                fifo_last_q[i] <= 1'b0;
            end
        end else begin
            done_q       <= 1'b0;
            pend_q       <= issue_s;
            pend_last_q  <= final_issue_s;
            fifo_count_q <= fifo_count_d;
            if (issue_s) begin
                ptr_q       <= ptr_q + ADDR_ONE;
                remaining_q <= remaining_q - LEN_ONE;
            end
            if (push_s) begin
                fifo_data_q[wr_ptr_q] <= ram_rd_data;
                fifo_last_q[wr_ptr_q] <= pend_last_q;
                wr_ptr_q              <= wr_ptr_q + 2'd1;
            end
            if (pop_s) begin
                rd_ptr_q <= rd_ptr_q + 2'd1;
            end
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        if (length != LEN_ZERO) begin
                            ptr_q       <= start_addr;
                            remaining_q <= length;
                            state_q     <= ST_RUN;
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (final_issue_s) begin
                        state_q <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (pop_s && m_last) begin
                        state_q <= ST_IDLE;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
            // Abort overrides everything above, including a same-cycle handshake.
            if (abort_s) begin
                state_q      <= ST_IDLE;
                pend_q       <= 1'b0;
                wr_ptr_q     <= 2'd0;
                rd_ptr_q     <= 2'd0;
                fifo_count_q <= 3'd0;
                done_q       <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_test_ram_reader.sv
// Scoreboard bench for test_ram_reader: stimulus pushes expected beats/done pulses, a negedge monitor checks them.
module tb_test_ram_reader;
    localparam int AW = 8;
    localparam int DW = 32;

    logic          rd_clk = 1'b0;
    logic          rd_rst = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] start_addr = '0;
    logic [AW:0]   length = '0;
    logic          m_ready = 1'b0;
    logic          busy, done, m_valid, m_last;
    logic [AW-1:0] ram_rd_addr;
    logic [DW-1:0] ram_rd_data;
    logic [DW-1:0] m_data;
`ifdef TEST_RAM_READER_ABORT_EN
    logic          abort = 1'b0;
`endif

    logic [DW-1:0] ram [256];
    int tests = 0;
    int fails = 0;
    int cyc = 0;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
        int            cyc;
    } beat_t;
    beat_t exp_q[$];
    int    done_q[$];
    beat_t mon_b;
    int    mon_d;
    logic          hold_v = 1'b0;
    logic [DW-1:0] hold_d = '0;
    logic          hold_l = 1'b0;

    test_ram_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .rd_clk      (rd_clk),
        .rd_rst      (rd_rst),
        .start       (start),
        .start_addr  (start_addr),
        .length      (length),
        .busy        (busy),
        .done        (done),
        .ram_rd_addr (ram_rd_addr),
        .ram_rd_data (ram_rd_data),
        .m_data      (m_data),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_last      (m_last)
`ifdef TEST_RAM_READER_ABORT_EN
        ,
        .abort       (abort)
`endif
    );

    always #5 rd_clk = ~rd_clk;

    // RAM read port model with one-cycle latency, plus cycle counter.
    always @(posedge rd_clk) begin
        cyc         <= cyc + 1;
        ram_rd_data <= ram[ram_rd_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: scores handshaken beats and done pulses, and checks stream stability.
    always @(negedge rd_clk) begin
        if (rd_rst) begin
            hold_v <= 1'b0;
        end else begin
            if (hold_v) begin
                check("hold_valid", {31'd0, m_valid}, 32'd1);
                check("hold_data", m_data, hold_d);
                check("hold_last", {31'd0, m_last}, {31'd0, hold_l});
            end
            hold_v <= m_valid & ~m_ready;
            hold_d <= m_data;
            hold_l <= m_last;
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_beat: got data %h last %0b expected no beat (cycle %0d)", m_data, m_last, cyc);
                end else begin
                    mon_b = exp_q.pop_front();
                    check("beat_data", m_data, mon_b.data);
                    check("beat_last", {31'd0, m_last}, {31'd0, mon_b.last});
                    if (mon_b.cyc >= 0) check("beat_cycle", cyc, mon_b.cyc);
                end
            end
            if (done) begin
                if (done_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_done: got done=1 expected 0 (cycle %0d)", cyc);
                end else begin
                    mon_d = done_q.pop_front();
                    if (mon_d >= 0) check("done_cycle", cyc, mon_d);
                end
            end
            check("inflight_le4", {31'd0, (int'(dut.fifo_count_q) + int'(dut.pend_q)) <= 4}, 32'd1);
        end
    end

    // Call at #1 after a posedge; returns at #1 in cycle t0+1.
    task automatic do_start(input logic [AW-1:0] a, input int len, input int nbeats,
                            input bit timed, input int done_off);
        int t0;
        logic [AW-1:0] wa;
        t0 = cyc;
        start_addr = a;
        length = len[AW:0];
        start = 1'b1;
        for (int i = 0; i < nbeats; i++) begin
            wa = a + i[AW-1:0];
            exp_q.push_back('{data: ram[wa], last: (i == len - 1), cyc: (timed ? t0 + 3 + i : -1)});
        end
        if (done_off >= 0) done_q.push_back(t0 + done_off);
        else if (done_off == -1) done_q.push_back(-1);
        @(posedge rd_clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_idle(input bit rnd, input int budget, input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || done_q.size() != 0 || busy) && n < budget) begin
            @(posedge rd_clk); #1;
            if (rnd) m_ready = 1'($urandom_range(0, 1));
            n++;
        end
        tests++;
        if (n >= budget) begin
            fails++;
            $display("FAIL %s_timeout: got %0d beats and %0d done pulses outstanding expected 0", name, exp_q.size(), done_q.size());
        end
        m_ready = 1'b1;
    endtask

    initial begin
        int n;
        for (int i = 0; i < 256; i++) ram[i] = 32'hA500_0000 + i;

        repeat (3) @(posedge rd_clk);
        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_valid", {31'd0, m_valid}, 32'd0);
        check("rst_last", {31'd0, m_last}, 32'd0);
        check("rst_data", m_data, 32'd0);
        check("rst_addr", {24'd0, ram_rd_addr}, 32'd0);
        rd_rst = 1'b0;
        m_ready = 1'b1;
        @(posedge rd_clk); #1;

        // Basic 8-word read with exact timing.
        do_start(8'h10, 8, 8, 1'b1, 11);
        check("t1_busy", {31'd0, busy}, 32'd1);
        check("t1_addr", {24'd0, ram_rd_addr}, 32'h10);
        wait_idle(1'b0, 100, "t1");

        // Address wrap-around.
        do_start(8'hFE, 4, 4, 1'b1, 7);
        check("wrap_addr", {24'd0, ram_rd_addr}, 32'hFE);
        wait_idle(1'b0, 100, "wrap");

        // Zero-length start.
        do_start(8'h30, 0, 0, 1'b1, 1);
        check("len0_busy", {31'd0, busy}, 32'd0);
        check("len0_done", {31'd0, done}, 32'd1);
        @(posedge rd_clk); #1;
        check("len0_busy2", {31'd0, busy}, 32'd0);
        wait_idle(1'b0, 20, "len0");

        // Full 256-word read under random backpressure; a start while busy is ignored.
        do_start(8'h00, 256, 256, 1'b0, -1);
        repeat (5) begin
            @(posedge rd_clk); #1;
            m_ready = 1'($urandom_range(0, 1));
        end
        start_addr = 8'h77;
        length = 9'd5;
        start = 1'b1;
        @(posedge rd_clk); #1;
        start = 1'b0;
        wait_idle(1'b1, 4000, "full");

        // Start in the done cycle is accepted.
        do_start(8'h40, 3, 3, 1'b1, 6);
        n = 0;
        while (!done && n < 30) begin
            @(posedge rd_clk); #1;
            n++;
        end
        check("b2b_done_seen", {31'd0, done}, 32'd1);
        do_start(8'h80, 2, 2, 1'b1, 5);
        check("b2b_busy", {31'd0, busy}, 32'd1);
        check("b2b_addr", {24'd0, ram_rd_addr}, 32'h80);
        wait_idle(1'b0, 50, "b2b");

        // Reset mid-transfer while stalled.
        m_ready = 1'b0;
        do_start(8'h50, 8, 0, 1'b0, -2);
        n = 0;
        while (!m_valid && n < 20) begin
            @(posedge rd_clk); #1;
            n++;
        end
        check("rst_mid_valid_seen", {31'd0, m_valid}, 32'd1);
        rd_rst = 1'b1;
        #1;
        check("rst_mid_valid", {31'd0, m_valid}, 32'd0);
        check("rst_mid_busy", {31'd0, busy}, 32'd0);
        check("rst_mid_last", {31'd0, m_last}, 32'd0);
        check("rst_mid_data", m_data, 32'd0);
        check("rst_mid_addr", {24'd0, ram_rd_addr}, 32'd0);
        @(posedge rd_clk); #1;
        rd_rst = 1'b0;
        m_ready = 1'b1;
        repeat (10) @(posedge rd_clk);
        #1;
        check("rst_mid_idle_busy", {31'd0, busy}, 32'd0);

`ifdef TEST_RAM_READER_ABORT_EN
        // Abort together with the third handshake.
        do_start(8'h20, 10, 3, 1'b1, 6);
        repeat (4) @(posedge rd_clk);
        #1;
        abort = 1'b1;
        @(posedge rd_clk); #1;
        abort = 1'b0;
        check("abort_valid", {31'd0, m_valid}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd1);
        repeat (10) @(posedge rd_clk);
        #1;
`endif

        check("left_beats", exp_q.size(), 32'd0);
        check("left_done", done_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish before time limit");
        $fatal(1, "watchdog");
    end

endmodule
